// File: rtl/fetch_stage_pkg.sv
// Shared constants, F/D payload type and the fetch address check for the F stage.
// Exception codes and address map match the CP0 and memory stages.
package fetch_stage_pkg;

    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] IM_BASE    = 32'h0000_3000;
    localparam logic [31:0] IM_END     = 32'h0000_6FFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        bd;
        logic        valid;
    } fd_payload_t;

    // Misaligned or outside instruction memory: the fetch raises AdEL.
    function automatic logic fetch_adel(input logic [31:0] pc,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
        return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
    endfunction

endpackage

// File: rtl/fetch_stage_fd_reg.sv
// F/D pipeline register: handler flush beats hold, hold beats bubble insert,
// and the fetched payload loads only when none of those is active.
module fd_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = fetch_stage_pkg::RESET_PC,
    parameter logic [31:0] HANDLER_PC = fetch_stage_pkg::HANDLER_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_hdl,
    input  logic        hold,
    input  logic        flush_bub,
    input  fd_payload_t d_in,
    output fd_payload_t d_out
);

    fd_payload_t fd_d, fd_q;

    always_comb begin
        fd_d = fd_q;
        if (flush_hdl) begin
            fd_d       = '0;
            fd_d.pc    = HANDLER_PC;
            fd_d.exc   = EXC_NONE;
        end else if (hold) begin
            fd_d = fd_q;
        end else if (flush_bub) begin
            // eret's bubble still advances the PC so D_PC tracks the fetch stream.
            fd_d       = '0;
            fd_d.pc    = d_in.pc;
            fd_d.exc   = EXC_NONE;
        end else begin
            fd_d = d_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fd_q       <= '0;
            fd_q.pc    <= RESET_PC;
            fd_q.exc   <= EXC_NONE;
        end else begin
            fd_q <= fd_d;
        end
    end

    assign d_out = fd_q;

endmodule

// File: rtl/fetch_stage.sv
// F stage: fetch PC register, AdEL check on the fetch address, and the F/D register.
// Redirect priority on each edge is req > stall > eret > normal advance.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] P_RESET_PC   = RESET_PC,
    parameter logic [31:0] P_HANDLER_PC = HANDLER_PC,
    parameter logic [31:0] P_IM_BASE    = IM_BASE,
    parameter logic [31:0] P_IM_END     = IM_END
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_PC,
    input  logic [31:0] F_instr,
    input  logic        stall,
    input  logic        req,
    input  logic        D_is_jb,
    input  logic        D_eret,
    output logic [31:0] F_PC,
    output logic [31:0] D_PC,
    output logic [31:0] D_instr,
    output logic [4:0]  D_exc,
    output logic        D_BD,
    output logic        D_valid
);

    logic [31:0] pc_d, pc_q;
    logic        f_adel;
    fd_payload_t fd_in, fd_out;

    assign f_adel = fetch_adel(pc_q, P_IM_BASE, P_IM_END);

    // next_PC is loaded verbatim; a bad target faults when fetched, not here.
    always_comb begin
        pc_d = pc_q;
        if (req)
            pc_d = P_HANDLER_PC;
        else if (!stall)
            pc_d = next_PC;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pc_q <= P_RESET_PC;
        else
            pc_q <= pc_d;
    end

    always_comb begin
        fd_in.pc    = pc_q;
        fd_in.instr = f_adel ? 32'h0 : F_instr;
        fd_in.exc   = f_adel ? EXC_ADEL : EXC_NONE;
        fd_in.bd    = D_is_jb;
        fd_in.valid = 1'b1;
    end

    fd_reg #(
        .RESET_PC   (P_RESET_PC),
        .HANDLER_PC (P_HANDLER_PC)
    ) u_fd_reg (
        .clk       (clk),
        .rst_n     (reset),
        .flush_hdl (req),
        .hold      (stall),
        .flush_bub (D_eret),
        .d_in      (fd_in),
        .d_out     (fd_out)
    );

    assign F_PC    = pc_q;
    assign D_PC    = fd_out.pc;
    assign D_instr = fd_out.instr;
    assign D_exc   = fd_out.exc;
    assign D_BD    = fd_out.bd;
    assign D_valid = fd_out.valid;

endmodule
